vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel/line counters and VGA sync/blank generation for a configurable
//   mode (default 640x480 @ 800x525 totals). hs/vs/blank are delayed by
//   PIPE_DLY pixel advances so they line up with a downstream pixel pipeline
//   (ROM + palette + output register) fed from DrawX/DrawY.
//
// Ports
//   vga_clk     in   pixel-domain clock, all state on rising edge
//   reset       in   synchronous, active-high
//   ce          in   pixel advance enable
//   DrawX       out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY       out  [9:0] vertical count, 0..V_TOTAL-1
//   hs, vs      out  active-low syncs, delayed PIPE_DLY pixels
//   blank       out  1 = visible (display enable), delayed PIPE_DLY pixels
//   line_start  out  one-clock pulse after a horizontal wrap
//   frame_start out  one-clock pulse after a frame wrap
//   frame_count out  [15:0] completed-frame counter (wraps mod 2^16)
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE_DLY  = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic x_wrap;
  logic y_wrap;
  logic hs_raw;
  logic vs_raw;
  logic blank_raw;

  assign x_wrap = (DrawX == H_LAST);
  assign y_wrap = (DrawY == V_LAST);

  always_comb begin
    hs_raw    = !((DrawX >= H_SYNC_ON) && (DrawX < H_SYNC_OFF));
    vs_raw    = !((DrawY >= V_SYNC_ON) && (DrawY < V_SYNC_OFF));
    blank_raw = (DrawX < H_VIS) && (DrawY < V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses are derived from the pre-edge counters, so they appear in the
      // cycle right after the wrap and drop whenever ce is low.
      line_start  <= ce & x_wrap;
      frame_start <= ce & x_wrap & y_wrap;
      if (ce) begin
        if (x_wrap) begin
          DrawX <= '0;
          if (y_wrap) begin
            DrawY       <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            DrawY <= DrawY + 10'd1;
          end
        end else begin
          DrawX <= DrawX + 10'd1;
        end
      end
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign hs    = hs_raw;
      assign vs    = vs_raw;
      assign blank = blank_raw;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_pipe;
      logic [PIPE_DLY-1:0] vs_pipe;
      logic [PIPE_DLY-1:0] blank_pipe;

      // Reset loads the idle level into every stage so a sync pulse that
      // was in flight when reset hit never reaches the outputs.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_pipe    <= '1;
          vs_pipe    <= '1;
          blank_pipe <= '0;
        end else if (ce) begin
          hs_pipe[0]    <= hs_raw;
          vs_pipe[0]    <= vs_raw;
          blank_pipe[0] <= blank_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe[i]    <= hs_pipe[i-1];
            vs_pipe[i]    <= vs_pipe[i-1];
            blank_pipe[i] <= blank_pipe[i-1];
          end
        end
      end

      assign hs    = hs_pipe[PIPE_DLY-1];
      assign vs    = vs_pipe[PIPE_DLY-1];
      assign blank = blank_pipe[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hsn; int hb;
    int vv; int vf; int vsn; int vb;
    int dly;
  } cfg_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
    logic        ls;
    logic        fs;
    logic [3:0]  hsp;
    logic [3:0]  vsp;
    logic [3:0]  bp;
  } mst_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  typedef struct packed {
    out_t d;
    out_t z;
    out_t s;
  } exp_t;

  localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t CZ = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t CS = '{10, 2, 3, 3, 6, 1, 2, 2, 2};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic ce      = 1'b0;

  logic [9:0]  x_d, y_d, x_z, y_z, x_s, y_s;
  logic        hs_d, vs_d, bl_d, ls_d, fs_d;
  logic        hs_z, vs_z, bl_z, ls_z, fs_z;
  logic        hs_s, vs_s, bl_s, ls_s, fs_s;
  logic [15:0] fc_d, fc_z, fc_s;

  out_t obs_d, obs_z, obs_s;
  assign obs_d = {x_d, y_d, hs_d, vs_d, bl_d, ls_d, fs_d, fc_d};
  assign obs_z = {x_z, y_z, hs_z, vs_z, bl_z, ls_z, fs_z, fc_z};
  assign obs_s = {x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s};

  int checks = 0;
  int errors = 0;
  int stepno = 0;
  exp_t sbq[$];
  mst_t md = '0, mz = '0, ms = '0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.PIPE_DLY(2)) dut_d (
    .vga_clk(vga_clk), .reset(reset), .ce(ce), .DrawX(x_d), .DrawY(y_d),
    .hs(hs_d), .vs(vs_d), .blank(bl_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_count(fc_d));

  vga_timing_gen #(.PIPE_DLY(0)) dut_z (
    .vga_clk(vga_clk), .reset(reset), .ce(ce), .DrawX(x_z), .DrawY(y_z),
    .hs(hs_z), .vs(vs_z), .blank(bl_z), .line_start(ls_z),
    .frame_start(fs_z), .frame_count(fc_z));

  vga_timing_gen #(.H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
                   .PIPE_DLY(2)) dut_s (
    .vga_clk(vga_clk), .reset(reset), .ce(ce), .DrawX(x_s), .DrawY(y_s),
    .hs(hs_s), .vs(vs_s), .blank(bl_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_count(fc_s));

  function automatic logic f_hraw(cfg_t c, logic [9:0] x);
    int xi;
    xi = int'(x);
    return !(xi >= c.hv + c.hf && xi < c.hv + c.hf + c.hsn);
  endfunction

  function automatic logic f_vraw(cfg_t c, logic [9:0] y);
    int yi;
    yi = int'(y);
    return !(yi >= c.vv + c.vf && yi < c.vv + c.vf + c.vsn);
  endfunction

  function automatic logic f_braw(cfg_t c, logic [9:0] x, logic [9:0] y);
    return (int'(x) < c.hv) && (int'(y) < c.vv);
  endfunction

  function automatic mst_t mstep(mst_t s, bit c_en, bit rst, cfg_t c);
    mst_t n;
    n = s;
    if (rst) begin
      n = '0;
      n.hsp = '1;
      n.vsp = '1;
    end else begin
      n.ls = 1'b0;
      n.fs = 1'b0;
      if (c_en) begin
        n.hsp = {s.hsp[2:0], f_hraw(c, s.x)};
        n.vsp = {s.vsp[2:0], f_vraw(c, s.y)};
        n.bp  = {s.bp[2:0], f_braw(c, s.x, s.y)};
        if (int'(s.x) == c.hv + c.hf + c.hsn + c.hb - 1) begin
          n.x  = '0;
          n.ls = 1'b1;
          if (int'(s.y) == c.vv + c.vf + c.vsn + c.vb - 1) begin
            n.y  = '0;
            n.fs = 1'b1;
            n.fc = s.fc + 16'd1;
          end else begin
            n.y = s.y + 10'd1;
          end
        end else begin
          n.x = s.x + 10'd1;
        end
      end
    end
    return n;
  endfunction

  function automatic out_t mout(mst_t s, cfg_t c);
    out_t o;
    o.x  = s.x;
    o.y  = s.y;
    o.ls = s.ls;
    o.fs = s.fs;
    o.fc = s.fc;
    if (c.dly == 0) begin
      o.hs = f_hraw(c, s.x);
      o.vs = f_vraw(c, s.y);
      o.bl = f_braw(c, s.x, s.y);
    end else begin
      o.hs = s.hsp[c.dly-1];
      o.vs = s.vsp[c.dly-1];
      o.bl = s.bp[c.dly-1];
    end
    return o;
  endfunction

  // One pixel clock: drive inputs, push the model's prediction, then pop and
  // compare it against all three instances after the edge.
  task automatic step(input bit c_en, input bit rst);
    exp_t e;
    reset = rst;
    ce    = c_en;
    md = mstep(md, c_en, rst, CD);
    mz = mstep(mz, c_en, rst, CZ);
    ms = mstep(ms, c_en, rst, CS);
    e.d = mout(md, CD);
    e.z = mout(mz, CZ);
    e.s = mout(ms, CS);
    sbq.push_back(e);
    @(posedge vga_clk);
    #1;
    stepno++;
    e = sbq.pop_front();
    checks++;
    if (obs_d !== e.d) begin
      errors++;
      $display("FAIL sb_dflt2 step %0d got %h exp %h", stepno, obs_d, e.d);
    end
    checks++;
    if (obs_z !== e.z) begin
      errors++;
      $display("FAIL sb_dflt0 step %0d got %h exp %h", stepno, obs_z, e.z);
    end
    checks++;
    if (obs_s !== e.s) begin
      errors++;
      $display("FAIL sb_small step %0d got %h exp %h", stepno, obs_s, e.s);
    end
    if (errors >= 20) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    step(0, 1);
    step(1, 1);
    checks++;
    if ({x_d, y_d, hs_d, vs_d, bl_d, ls_d, fs_d, fc_d} !== {20'd0, 5'b11000, 16'd0}) begin
      errors++;
      $display("FAIL rst_dflt2 got %h exp %h", obs_d, {20'd0, 5'b11000, 16'd0});
    end
    checks++;
    if ({x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s} !== {20'd0, 5'b11000, 16'd0}) begin
      errors++;
      $display("FAIL rst_small got %h exp %h", obs_s, {20'd0, 5'b11000, 16'd0});
    end
    checks++;
    // No delay stages: blank shows raw visibility of (0,0) immediately.
    if ({hs_z, vs_z, bl_z} !== 3'b111) begin
      errors++;
      $display("FAIL rst_dflt0 got %b exp 111", {hs_z, vs_z, bl_z});
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      checks++;
      if ({ls_d, fs_d, ls_z, fs_z, ls_s, fs_s} !== 6'b0) begin
        errors++;
        $display("FAIL rst_exit_pulse got %b exp 000000", {ls_d, fs_d, ls_z, fs_z, ls_s, fs_s});
      end
    end
  endtask

  task automatic test_line();
    int ls_cnt = 0, fs_cnt = 0;
    int st_d = -1, st_z = -1, len_d = 0, len_z = 0;
    logic ph_d = 1'b1, ph_z = 1'b1;
    step(1, 1);
    for (int i = 0; i < 800; i++) begin
      step(1, 0);
      if (ls_d) ls_cnt++;
      if (fs_d) fs_cnt++;
      if (!hs_d && ph_d && st_d < 0) st_d = int'(x_d);
      if (!hs_z && ph_z && st_z < 0) st_z = int'(x_z);
      if (!hs_d) len_d++;
      if (!hs_z) len_z++;
      ph_d = hs_d;
      ph_z = hs_z;
    end
    checks++;
    if (x_d !== 10'd0 || y_d !== 10'd1) begin
      errors++;
      $display("FAIL line_pos got %0d,%0d exp 0,1", x_d, y_d);
    end
    checks++;
    if (ls_cnt != 1 || fs_cnt != 0) begin
      errors++;
      $display("FAIL line_pulses got ls=%0d fs=%0d exp ls=1 fs=0", ls_cnt, fs_cnt);
    end
    checks++;
    if (st_z != 656 || len_z != 96) begin
      errors++;
      $display("FAIL hsync_dly0 got start=%0d len=%0d exp start=656 len=96", st_z, len_z);
    end
    checks++;
    if (st_d != 658 || len_d != 96) begin
      errors++;
      $display("FAIL hsync_dly2 got start=%0d len=%0d exp start=658 len=96", st_d, len_d);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_low = 0, bl_hi = 0;
    step(1, 1);
    for (int i = 0; i < 198; i++) begin
      step(1, 0);
      if (fs_s) fs_cnt++;
      if (!vs_s) vs_low++;
      if (bl_s) bl_hi++;
    end
    checks++;
    if (fs_cnt != 1 || fc_s !== 16'd1) begin
      errors++;
      $display("FAIL frame_wrap got fs=%0d fc=%0d exp fs=1 fc=1", fs_cnt, fc_s);
    end
    checks++;
    if (vs_low != 36) begin
      errors++;
      $display("FAIL vsync_len got %0d exp 36", vs_low);
    end
    checks++;
    if (bl_hi != 60) begin
      errors++;
      $display("FAIL visible_len got %0d exp 60", bl_hi);
    end
  endtask

  task automatic test_ce_alt();
    int p1 = -1, p2 = -1;
    logic [36:0] prev;
    step(1, 1);
    for (int i = 1; i <= 800; i++) begin
      prev = {x_s, y_s, hs_s, vs_s, bl_s, fc_s};
      step(i % 2 == 1, 0);
      if (i % 2 == 0) begin
        checks++;
        if ({x_s, y_s, hs_s, vs_s, bl_s, fc_s} !== prev) begin
          errors++;
          $display("FAIL ce_hold step %0d got %h exp %h", i, {x_s, y_s, hs_s, vs_s, bl_s, fc_s}, prev);
        end
      end
      if (fs_s) begin
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
    end
    checks++;
    if (p1 != 395 || p2 - p1 != 396) begin
      errors++;
      $display("FAIL ce_frame_period got first=%0d period=%0d exp first=395 period=396", p1, p2 - p1);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    step(1, 1);
    while (n < 400 && !(x_s == 10'd13 && y_s == 10'd7)) begin
      step(1, 0);
      n++;
    end
    checks++;
    if (x_s !== 10'd13 || y_s !== 10'd7) begin
      errors++;
      $display("FAIL midrst_reach got %0d,%0d exp 13,7", x_s, y_s);
    end
    step(1, 1);
    checks++;
    if ({x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s} !== {20'd0, 5'b11000, 16'd0}) begin
      errors++;
      $display("FAIL midrst_state got %h exp %h", obs_s, {20'd0, 5'b11000, 16'd0});
    end
    for (int i = 0; i < 30; i++) begin
      step(1, 0);
      checks++;
      if (!vs_s || (i < 10 && !hs_s)) begin
        errors++;
        $display("FAIL midrst_residue step %0d got hs=%b vs=%b exp hs=1 vs=1", i, hs_s, vs_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 499) == 0);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d exp 0", sbq.size());
    end
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_line();
    test_frame();
    test_ce_alt();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
